muldiv_unit: RTL

Multi-cycle signed multiply/divide unit for the multi-cycle MIPS datapath. It is the responder to the control FSM's `DivCtrl`/`MultCtrl` start pulses. It latches operands from the A/B registers and iterates one bit per cycle. It writes the 64-bit result into the HI/LO registers and reports completion with a one-cycle `done` pulse, plus `div_zero` for the divide-by-zero exception path.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide unit: one bit per cycle, results into HI/LO.
// Define MULDIV_MULT_EN to compile in the shift-add multiply path.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             mult_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
`ifdef MULDIV_MULT_EN
    MULT_RUN = 2'd2,
`endif
    FIN      = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_a_q;
  logic               neg_r_q;
  logic               skip_q;
  logic               zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     trial;
  logic [ACC_W-1:0]   div_next;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;
`ifdef MULDIV_MULT_EN
  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_next;
  logic [ACC_W-1:0]   mul_prod;
`endif

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

  // Operand magnitudes and one restoring-division step (acc = {remainder, dividend/quotient}).
  always_comb begin
    mag_a = op_a[WIDTH-1] ? WIDTH'(-op_a) : op_a;
    mag_b = op_b[WIDTH-1] ? WIDTH'(-op_b) : op_b;
    trial = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!trial[WIDTH]) begin
      div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[ACC_W-2:0], 1'b0};
    end
    rem_mag = div_next[ACC_W-1:WIDTH];
    quo_mag = div_next[WIDTH-1:0];
    div_hi  = neg_a_q ? WIDTH'(-rem_mag) : rem_mag;
    div_lo  = neg_r_q ? WIDTH'(-quo_mag) : quo_mag;
  end

`ifdef MULDIV_MULT_EN
  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_prod = neg_r_q ? ACC_W'(-mul_next) : mul_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_a_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      skip_q     <= 1'b0;
      zero_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          state_q <= IDLE;
          if (div_start) begin
            state_q <= DIV_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= {{WIDTH{1'b0}}, mag_a};
            opnd_q  <= mag_b;
            neg_a_q <= op_a[WIDTH-1];
            neg_r_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            skip_q  <= (op_b == '0);
            zero_q  <= (op_b == '0);
          end else if (mult_start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef MULDIV_MULT_EN
            state_q <= MULT_RUN;
            acc_q   <= {{WIDTH{1'b0}}, mag_b};
            opnd_q  <= mag_a;
            neg_a_q <= op_a[WIDTH-1];
            neg_r_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            skip_q  <= 1'b0;
            zero_q  <= 1'b0;
`else
            // No multiplier: complete after one cycle so the requester never stalls.
            state_q <= DIV_RUN;
            skip_q  <= 1'b1;
            zero_q  <= 1'b0;
`endif
          end
        end
        DIV_RUN: begin
          if (skip_q) begin
            state_q    <= FIN;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            div_zero_q <= zero_q;
          end else begin
            acc_q <= div_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hi_q    <= div_hi;
              lo_q    <= div_lo;
            end
          end
        end
`ifdef MULDIV_MULT_EN
        MULT_RUN: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= mul_prod[ACC_W-1:WIDTH];
            lo_q    <= mul_prod[WIDTH-1:0];
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
